// File: rtl/airlock_pkg.sv
// Shared airlock definitions: state encoding and default cycle constants,
// used by both the fill/pressurize and evacuate/depressurize sequencers.
package airlock_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PUMP   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_PAUSE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PUMP   = ST_PUMP,
    SETTLE = ST_SETTLE,
    DONE   = ST_DONE,
    PAUSE  = ST_PAUSE
  } airlock_state_t;

  localparam int unsigned DEF_PUMP_CYCLES   = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 2;
  localparam int unsigned DEF_CW            = 4;

endpackage

// File: rtl/airlock_down_counter.sv
// Loadable down counter that saturates at zero; synchronous active-low reset.
module airlock_down_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge Clock) begin
    if (!Reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - CW'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/evacuate_and_depressurize.sv
// Airlock pump-down sequencer: pump for PUMP_CYCLES, settle, then report Evacuated.
// Optional EANDD_HOLD_EN: a door opening pauses the sequence instead of aborting.
module evacuate_and_depressurize
  import airlock_pkg::*;
#(
  parameter int unsigned PUMP_CYCLES   = DEF_PUMP_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CW            = DEF_CW
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          begin_EandD,
  input  logic          InnerClosed,
  input  logic          OuterClosed,
  input  logic          Pressurized,
  output logic          EandD,
  output logic          Evacuated,
  output logic          Busy,
  output logic          Aborted,
  output logic [CW-1:0] Remaining
);

  localparam logic [CW-1:0] PUMP_LOAD   = CW'(PUMP_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  airlock_state_t state, nxt;
  logic           load, dec, abort_c, zero, doors_ok;
  logic [CW-1:0]  load_val, cnt;
`ifdef EANDD_HOLD_EN
  logic           resume_settle, resume_settle_nxt;
`endif

  assign doors_ok  = InnerClosed & OuterClosed;
  assign Remaining = cnt;

  airlock_down_counter #(.CW(CW)) u_cnt (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (cnt),
    .zero     (zero)
  );

  // Next-state and counter control; an abort overrides everything else.
  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = '0;
    dec      = 1'b0;
    abort_c  = 1'b0;
`ifdef EANDD_HOLD_EN
    resume_settle_nxt = resume_settle;
`endif
    case (state)
      IDLE: begin
        if (begin_EandD && doors_ok && Pressurized) begin
          nxt      = PUMP;
          load     = 1'b1;
          load_val = PUMP_LOAD;
        end
      end
      PUMP, SETTLE: begin
        if (!begin_EandD) begin
          abort_c = 1'b1;
        end else if (!doors_ok) begin
`ifdef EANDD_HOLD_EN
          // The interrupted cycle still counts as run; a finished pump resumes into settle.
          nxt               = PAUSE;
          resume_settle_nxt = (state == SETTLE);
          if ((state == PUMP) && zero) begin
            resume_settle_nxt = 1'b1;
            load              = 1'b1;
            load_val          = SETTLE_LOAD;
          end else begin
            dec = 1'b1;
          end
`else
          abort_c = 1'b1;
`endif
        end else if (zero) begin
          if (state == PUMP) begin
            nxt      = SETTLE;
            load     = 1'b1;
            load_val = SETTLE_LOAD;
          end else begin
            nxt = DONE;
          end
        end else begin
          dec = 1'b1;
        end
      end
      DONE: begin
        if (!begin_EandD)
          nxt = IDLE;
      end
`ifdef EANDD_HOLD_EN
      PAUSE: begin
        if (!begin_EandD)
          abort_c = 1'b1;
        else if (doors_ok)
          nxt = resume_settle ? SETTLE : PUMP;
      end
`endif
      default: nxt = IDLE;
    endcase
    if (abort_c) begin
      nxt      = IDLE;
      load     = 1'b1;
      load_val = '0;
    end
  end

  // State register with outputs decoded from the next state so they align with it.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= IDLE;
      EandD     <= 1'b0;
      Evacuated <= 1'b0;
      Busy      <= 1'b0;
      Aborted   <= 1'b0;
`ifdef EANDD_HOLD_EN
      resume_settle <= 1'b0;
`endif
    end else begin
      state     <= nxt;
      EandD     <= (nxt == PUMP);
      Evacuated <= (nxt == DONE);
      Busy      <= (nxt == PUMP) || (nxt == SETTLE) || (nxt == PAUSE);
      Aborted   <= abort_c;
`ifdef EANDD_HOLD_EN
      resume_settle <= resume_settle_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_evacuate_and_depressurize.sv
// Scoreboard bench for evacuate_and_depressurize (default build, 8 pump / 2 settle).
module tb_evacuate_and_depressurize;

  localparam int unsigned PUMP   = 8;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CW     = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          begin_EandD = 1'b0;
  logic          InnerClosed = 1'b1;
  logic          OuterClosed = 1'b1;
  logic          Pressurized = 1'b1;
  logic          EandD, Evacuated, Busy, Aborted;
  logic [CW-1:0] Remaining;

  evacuate_and_depressurize #(
    .PUMP_CYCLES(PUMP), .SETTLE_CYCLES(SETTLE), .CW(CW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .begin_EandD(begin_EandD),
    .InnerClosed(InnerClosed), .OuterClosed(OuterClosed), .Pressurized(Pressurized),
    .EandD(EandD), .Evacuated(Evacuated), .Busy(Busy), .Aborted(Aborted),
    .Remaining(Remaining)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic e, v, b, a;
    int   r;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: phase 0 idle, 1 pump, 2 settle, 3 done
  int   m_ph = 0;
  int   m_cnt = 0;
  logic m_ab = 1'b0;

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    if (obs != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic void model_step();
    logic dok;
    dok  = InnerClosed && OuterClosed;
    m_ab = 1'b0;
    if (!Reset) begin
      m_ph = 0; m_cnt = 0;
    end else if (m_ph == 0) begin
      if (begin_EandD && dok && Pressurized) begin
        m_ph = 1; m_cnt = PUMP - 1;
      end
    end else if (m_ph == 3) begin
      if (!begin_EandD) m_ph = 0;
    end else if (!begin_EandD || !dok) begin
      m_ph = 0; m_cnt = 0; m_ab = 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
    end else if (m_ph == 1) begin
      m_ph = 2; m_cnt = SETTLE - 1;
    end else begin
      m_ph = 3;
    end
  endfunction

  // Apply current inputs for one edge, predict, then compare one cycle's outputs.
  task automatic step();
    exp_t x;
    model_step();
    x.e = (m_ph == 1);
    x.v = (m_ph == 3);
    x.b = (m_ph == 1) || (m_ph == 2);
    x.a = m_ab;
    x.r = m_cnt;
    q.push_back(x);
    @(posedge Clock);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 0, 1);
    end else begin
      x = q.pop_front();
      chk("EandD", int'(EandD), int'(x.e));
      chk("Evacuated", int'(Evacuated), int'(x.v));
      chk("Busy", int'(Busy), int'(x.b));
      chk("Aborted", int'(Aborted), int'(x.a));
      chk("Remaining", int'(Remaining), x.r);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_in(input logic b, input logic ic, input logic oc, input logic p);
    begin_EandD = b; InnerClosed = ic; OuterClosed = oc; Pressurized = p;
  endtask

  int pump_cnt, evac_at, ab_cnt;

  initial begin
    #2;
    // reset state
    Reset = 1'b0;
    set_in(1'b0, 1'b1, 1'b1, 1'b1);
    steps(2);
    Reset = 1'b1;
    steps(1);

    // nominal run, Pressurized drop mid-sequence is ignored
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    pump_cnt = 0; evac_at = -1; ab_cnt = 0;
    for (int i = 1; i <= 13; i++) begin
      if (i == 3) Pressurized = 1'b0;
      step();
      if (EandD) pump_cnt++;
      if (Aborted) ab_cnt++;
      if (Evacuated && evac_at < 0) evac_at = i;
    end
    chk("nominal_pump_cycles", pump_cnt, PUMP);
    chk("nominal_evac_cycle", evac_at, PUMP + SETTLE + 1);
    chk("nominal_no_abort", ab_cnt, 0);

    // release from DONE, then re-request runs the full sequence again
    begin_EandD = 1'b0;
    steps(2);
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    pump_cnt = 0; evac_at = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (EandD) pump_cnt++;
      if (Evacuated && evac_at < 0) evac_at = i;
    end
    chk("rerun_pump_cycles", pump_cnt, PUMP);
    chk("rerun_evac_cycle", evac_at, PUMP + SETTLE + 1);
    begin_EandD = 1'b0;
    steps(1);

    // start gating: outer door open, then not pressurized
    set_in(1'b1, 1'b1, 1'b0, 1'b1);
    steps(5);
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    steps(5);

    // door abort in the middle of pumping
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    steps(4);
    chk("abort_pre_remaining", int'(Remaining), 4);
    InnerClosed = 1'b0;
    steps(1);
    chk("abort_pulse", int'(Aborted), 1);
    InnerClosed = 1'b1;
    begin_EandD = 1'b0;
    steps(2);

    // door opens on the last pump cycle: abort wins over expiry
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    steps(PUMP);
    chk("collision_remaining", int'(Remaining), 0);
    chk("collision_still_pumping", int'(EandD), 1);
    OuterClosed = 1'b0;
    steps(1);
    chk("collision_abort", int'(Aborted), 1);
    OuterClosed = 1'b1;
    begin_EandD = 1'b0;
    steps(4);
    chk("collision_no_evac", int'(Evacuated), 0);

    // reset during settle, then restart with begin held high
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    steps(PUMP + 1);
    chk("settle_busy", int'(Busy), 1);
    chk("settle_pump_off", int'(EandD), 0);
    Reset = 1'b0;
    steps(1);
    Reset = 1'b1;
    steps(1);
    chk("restart_pump", int'(EandD), 1);
    chk("restart_remaining", int'(Remaining), PUMP - 1);
    steps(PUMP + SETTLE + 1);
    chk("restart_done", int'(Evacuated), 1);
    begin_EandD = 1'b0;
    steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
